// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS single-cycle datapath front end.
// Holds the fetch FSM states, the default reset vector and the next-PC select codes.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FAULT = 2'd2
   } pc_state_e;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      SEL_PC4 = 2'd0,
      SEL_BR  = 2'd1,
      SEL_J   = 2'd2,
      SEL_JR  = 2'd3
   } npc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Instruction-memory fetch handshake between the PC stage (master) and imem (slave).
interface pc_unit_if;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] pc;

   modport master (output imem_req, output pc, input imem_ready);
   modport slave  (input imem_req, input pc, output imem_ready);
endinterface

// File: rtl/branch_target_adder.sv
// Branch target = pc_plus4 + (sign-extended word offset << 2), modulo 2^32.
// Offset bits [31:30] fall off the shift, as the ISA intends.
module branch_target_adder (
   input  logic        [31:0] pc_plus4,
   input  logic signed [31:0] branch_offset,
   output logic        [31:0] target
);

   logic signed [31:0] byte_offset;

   always_comb begin
      byte_offset = branch_offset <<< 2;
      target      = pc_plus4 + $unsigned(byte_offset);
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, fetch FSM (HOLD/FETCH/FAULT), next-PC priority mux,
// misaligned-target detection and a retired-instruction counter.
module pc_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic               clk,
   input  logic               reset,
   pc_unit_if.master          imem,
   input  logic               branch,
   input  logic               zero,
   input  logic        [31:0] branch_offset,
   input  logic               jump,
   input  logic        [31:0] jump_address,
   input  logic               jr,
   input  logic        [31:0] jr_target,
   output logic        [31:0] pc_plus4,
   output logic         [3:0] pc_upper,
   output logic               retire,
   output logic               misaligned,
   output logic        [31:0] instr_count
);

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] cnt_q, cnt_d;
   logic        misaligned_q, misaligned_d;

   npc_sel_e    sel;
   logic [31:0] br_target;
   logic [31:0] next_pc;

   branch_target_adder u_bta (
      .pc_plus4      (pc_plus4),
      .branch_offset (branch_offset),
      .target        (br_target)
   );

   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      pc_upper = pc_plus4[31:28];

      // jr outranks jump, which outranks a taken branch; simultaneous flags are legal
      if (jr)                 sel = SEL_JR;
      else if (jump)          sel = SEL_J;
      else if (branch & zero) sel = SEL_BR;
      else                    sel = SEL_PC4;

      case (sel)
         SEL_JR:  next_pc = jr_target;
         SEL_J:   next_pc = jump_address;
         SEL_BR:  next_pc = br_target;
         default: next_pc = pc_plus4;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      cnt_d        = cnt_q;
      misaligned_d = misaligned_q;
      imem.imem_req = 1'b0;
      retire        = 1'b0;

      case (state_q)
         ST_HOLD: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem.imem_req = 1'b1;
            if (imem.imem_ready) begin
               retire = 1'b1;
               cnt_d  = cnt_q + 32'd1;
               // A misaligned target still retires the current instruction but never reaches pc
               if (next_pc[1:0] != 2'b00) begin
                  misaligned_d = 1'b1;
                  state_d      = ST_FAULT;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_HOLD;
         pc_q         <= RESET_VECTOR;
         cnt_q        <= 32'd0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         cnt_q        <= cnt_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign imem.pc     = pc_q;
   assign misaligned  = misaligned_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit: sequential fetch, jumps, branches, priority,
// imem stalls, wrap-around and the misaligned-target fault.
module tb_pc_unit;
   import mips_pkg::*;

   logic        clk;
   logic        reset;
   logic        branch, zero, jump, jr;
   logic [31:0] branch_offset, jump_address, jr_target;
   logic [31:0] pc_plus4;
   logic  [3:0] pc_upper;
   logic        retire, misaligned;
   logic [31:0] instr_count;

   int n_vec  = 0;
   int n_miss = 0;

   pc_unit_if imem ();

   pc_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem          (imem),
      .branch        (branch),
      .zero          (zero),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_address  (jump_address),
      .jr            (jr),
      .jr_target     (jr_target),
      .pc_plus4      (pc_plus4),
      .pc_upper      (pc_upper),
      .retire        (retire),
      .misaligned    (misaligned),
      .instr_count   (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      branch = 1'b0; zero = 1'b0; jump = 1'b0; jr = 1'b0;
      branch_offset = 32'h0; jump_address = 32'h0; jr_target = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear_ctl();
      imem.imem_ready = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      // HOLD cycle right after reset
      chk("rst_pc",        imem.pc,     32'h0);
      chk("rst_pc_plus4",  pc_plus4,    32'h4);
      chk("rst_pc_upper",  {28'h0, pc_upper}, 32'h0);
      chk("rst_imem_req",  {31'h0, imem.imem_req}, 32'h0);
      chk("rst_retire",    {31'h0, retire}, 32'h0);
      chk("rst_misaligned",{31'h0, misaligned}, 32'h0);
      chk("rst_count",     instr_count, 32'h0);

      tick();
      chk("fetch0_pc",     imem.pc, 32'h0);
      chk("fetch0_req",    {31'h0, imem.imem_req}, 32'h1);
      chk("fetch0_retire", {31'h0, retire}, 32'h1);
      tick(); chk("seq_pc4",  imem.pc, 32'h4);
      tick(); chk("seq_pc8",  imem.pc, 32'h8);
      tick(); chk("seq_pc12", imem.pc, 32'hC);
      chk("seq_count3", instr_count, 32'd3);
      chk("seq_upper",  {28'h0, pc_upper}, 32'h0);

      jump = 1'b1; jump_address = 32'h3000_0010;
      tick(); chk("j_setup_pc", imem.pc, 32'h3000_0010);
      jump = 1'b0; #1;
      chk("j_pc_upper", {28'h0, pc_upper}, 32'h3);
      jump = 1'b1; jump_address = 32'h3000_00E0;
      tick(); chk("j_pc", imem.pc, 32'h3000_00E0);
      chk("j_count", instr_count, 32'd5);

      jump_address = 32'h0000_0100;
      tick(); chk("br_setup_pc", imem.pc, 32'h100);
      clear_ctl(); branch = 1'b1; zero = 1'b1; branch_offset = 32'hFFFF_FFFE;
      tick(); chk("br_taken_pc", imem.pc, 32'hFC);
      clear_ctl(); jump = 1'b1; jump_address = 32'h0000_0100;
      tick(); chk("br_setup2_pc", imem.pc, 32'h100);
      clear_ctl(); branch = 1'b1; zero = 1'b0; branch_offset = 32'hFFFF_FFFE;
      tick(); chk("br_not_taken_pc", imem.pc, 32'h104);

      jr = 1'b1; jr_target = 32'h400; jump = 1'b1; jump_address = 32'h800;
      branch = 1'b1; zero = 1'b1; branch_offset = 32'h10;
      tick(); chk("prio_pc", imem.pc, 32'h400);
      chk("prio_count", instr_count, 32'd10);
      clear_ctl();

      imem.imem_ready = 1'b0; jump = 1'b1; jump_address = 32'h500;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_retire", {31'h0, retire}, 32'h0);
         chk("stall_req",    {31'h0, imem.imem_req}, 32'h1);
         tick();
         chk("stall_pc",     imem.pc, 32'h400);
      end
      chk("stall_count", instr_count, 32'd10);
      imem.imem_ready = 1'b1; #1;
      chk("unstall_retire", {31'h0, retire}, 32'h1);
      tick(); chk("unstall_pc", imem.pc, 32'h500);
      chk("unstall_count", instr_count, 32'd11);

      jump_address = 32'hFFFF_FFFC;
      tick(); chk("wrap_setup_pc", imem.pc, 32'hFFFF_FFFC);
      jump = 1'b0; #1;
      chk("wrap_pc_plus4", pc_plus4, 32'h0);
      chk("wrap_pc_upper", {28'h0, pc_upper}, 32'h0);
      tick(); chk("wrap_pc", imem.pc, 32'h0);
      chk("wrap_count", instr_count, 32'd13);

      jump = 1'b1; jump_address = 32'h200;
      tick(); chk("mis_setup_pc", imem.pc, 32'h200);
      clear_ctl(); jr = 1'b1; jr_target = 32'h402;
      tick();
      chk("mis_flag",   {31'h0, misaligned}, 32'h1);
      chk("mis_pc",     imem.pc, 32'h200);
      chk("mis_count",  instr_count, 32'd15);
      chk("mis_req",    {31'h0, imem.imem_req}, 32'h0);
      chk("mis_retire", {31'h0, retire}, 32'h0);
      clear_ctl();
      tick();
      chk("fault_pc",    imem.pc, 32'h200);
      chk("fault_req",   {31'h0, imem.imem_req}, 32'h0);
      chk("fault_count", instr_count, 32'd15);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rerst_pc",    imem.pc, 32'h0);
      chk("rerst_flag",  {31'h0, misaligned}, 32'h0);
      chk("rerst_count", instr_count, 32'h0);
      chk("rerst_req",   {31'h0, imem.imem_req}, 32'h0);
      tick();
      chk("rerst_fetch_req", {31'h0, imem.imem_req}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the 32-bit MIPS single-cycle datapath. Holds the PC register and selects the next PC from PC+4, the branch target, the jump address from `jump_concat`, or a register target. It supplies `pc_upper` (PC+4[31:28]) back to `jump_concat` and handshakes with instruction memory. It also detects misaligned targets and counts retired instructions.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `imem_ready`  in  1  instruction memory has returned the instruction at `pc` this cycle.
- `branch`  in  1  current instruction is a conditional branch.
- `zero`  in  1  ALU zero flag; branch taken = `branch & zero`.
- `branch_offset`  in  32  sign-extended immediate, word offset, not yet shifted.
- `jump`  in  1  current instruction is J/JAL.
- `jump_address`  in  32  `{pc_upper, instr[25:0], 2'b00}` from `jump_concat`.
- `jr`  in  1  current instruction is JR.
- `jr_target`  in  32  register-file read data for JR.
- `pc`  out  32  current PC (registered).
- `pc_plus4`  out  32  `pc + 4`, combinational.
- `pc_upper`  out  4  `pc_plus4[31:28]`, to `jump_concat.pc_plus4`.
- `imem_req`  out  1  fetch request for address `pc`.
- `retire`  out  1  one-cycle pulse, instruction at `pc` completes this cycle.
- `misaligned`  out  1  sticky fault flag.
- `instr_count`  out  32  retired-instruction counter.

## Operation
- FSM states are HOLD, FETCH and FAULT.
- Reset (all states) forces HOLD, `pc=RESET_VECTOR`, `instr_count=0`, `misaligned=0`. Reset wins over every other input.
- HOLD:
  - `imem_req=0`, `retire=0`.
  - Next cycle goes to FETCH unconditionally, so there is one idle cycle after reset.
- FETCH:
  - `imem_req=1`.
  - While `imem_ready=0`, the PC is held, all control inputs are ignored and `retire=0`.
  - When `imem_ready=1`, `retire=1` and the next PC is chosen by priority: `jr` → `jr_target`; else `jump` → `jump_address`; else `branch&zero` → `pc_plus4 + (branch_offset<<2)`; else `pc_plus4`.
- Misaligned target (selected next PC has bits [1:0] ≠ 0):
  - The PC is not updated, `misaligned` sets and the FSM goes to FAULT.
  - The instruction still retires, so `retire=1` and `instr_count` increments.
- FAULT:
  - `imem_req=0`, `retire=0` and the PC is frozen.
  - The FSM leaves FAULT only on reset.
- Arithmetic:
  - All additions are modulo 2^32.
  - `0xFFFF_FFFC + 4 = 0x0000_0000`.
  - Negative offsets wrap likewise; the shift discards `branch_offset[31:30]`.
- `instr_count` increments on each `retire`; it wraps from 0xFFFF_FFFF to 0.
- Multiple control flags set at once are legal and resolved by the priority above, with no error.

## Timing
- `pc`, `instr_count`, `misaligned` and the FSM state are registered. `pc_plus4`, `pc_upper`, `imem_req` and `retire` are combinational from state, `pc` and `imem_ready`.
- Reset values:
  - `pc=RESET_VECTOR`.
  - `pc_plus4=RESET_VECTOR+4`, `pc_upper=(RESET_VECTOR+4)[31:28]`.
  - `imem_req=0`, `retire=0`, `misaligned=0`, `instr_count=0`.
- Redirect latency: a new PC is visible on `pc` one cycle after the `imem_ready` cycle that selected it.
- With `imem_ready` tied high, throughput is one instruction per cycle after the single HOLD cycle.
- The `jump_concat` path is combinational within one cycle: `pc` → `pc_upper` → `jump_address` → next-PC mux.

## Structure
- Package `mips_pkg` holds:
  - the state enum (HOLD, FETCH, FAULT);
  - the default reset vector constant;
  - the next-PC select encoding (`SEL_PC4`, `SEL_BR`, `SEL_J`, `SEL_JR`).
- One sub-module, `branch_target_adder`: inputs `pc_plus4` and `branch_offset`, output the 32-bit target. It is combinational and reusable by the compare unit.
- The PC register, FSM, priority mux, alignment check and counter stay in `pc_unit`.

## Test plan
- Reset, then `imem_ready=1`, no control → `pc` is 0 in the HOLD cycle, then 0, 4, 8, 12 on successive cycles; `instr_count=3` after the third retire; `pc_upper=0`.
- PC `0x3000_0010`, `jump=1`, `jump_address=0x3000_00E0` → next `pc=0x3000_00E0`; `pc_upper=4'h3` before the jump.
- PC `0x100`, `branch=1`, `zero=1`, `branch_offset=32'hFFFF_FFFE` → next `pc=0xFC`. Same stimulus with `zero=0` → next `pc=0x104`.
- `jr=1`, `jump=1` and a taken branch all set together, `jr_target=0x400` → next `pc=0x400`.
- PC `0x200`, `jr=1`, `jr_target=0x402` → `misaligned=1`, `pc` stays `0x200`, `imem_req=0` thereafter; asserting `reset` returns `pc=0`, `misaligned=0`.
- `imem_ready` low for 3 cycles with `jump` asserted → `pc` held, no `retire`. `imem_ready` rising → jump taken on the next edge. With `pc=0xFFFF_FFFC` and no control → `pc` wraps to 0.
